video_core_avs_csr: RTL and testbench

// - Avalon-MM slave (responder) control/status register file for one video pipeline core
//   (bar, sprite, pacman, rgb2gray). It terminates the avs_* writes issued by the top-level or bypass control.
// - Drives the core's bypass/mode controls, optionally frame-synchronised.
// - Collects sticky line-buffer error flags and a frame counter, and makes them readable over Avalon.

---
 rtl/video_csr_pkg.sv | 27 ++
 rtl/video_core_avs_csr.sv | 159 +++++++++++++++
 tb/tb_video_core_avs_csr.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/video_csr_pkg.sv
// Shared definitions for the video core Avalon-MM CSR block: register offsets,
// field bit positions and the CTRL register layout.
package video_csr_pkg;

  localparam int unsigned CSR_CTRL      = 0;
  localparam int unsigned CSR_STATUS    = 1;
  localparam int unsigned CSR_FRAME_CNT = 2;
  localparam int unsigned CSR_ID        = 3;

  localparam int unsigned CTRL_BYPASS_BIT = 0;
  localparam int unsigned CTRL_MODE_LSB   = 4;
  localparam int unsigned CTRL_MODE_MSB   = 7;

  localparam int unsigned STAT_BYPASS_BIT  = 0;
  localparam int unsigned STAT_OVF_BIT     = 1;
  localparam int unsigned STAT_UNF_BIT     = 2;
  localparam int unsigned STAT_PENDING_BIT = 3;

  localparam int unsigned NUM_STICKY = 2;
  localparam int unsigned FCNT_W     = 16;

  typedef struct packed {
    logic [3:0] mode;
    logic       bypass;
  } ctrl_t;

endpackage

// File: rtl/video_core_avs_csr.sv
// Avalon-MM control/status register file for one video pipeline core: bypass/mode
// control (optionally frame-synchronised), sticky line-buffer errors, frame counter.
module video_core_avs_csr
  import video_csr_pkg::*;
#(
  parameter int unsigned ADDR_W     = 2,
  parameter logic [31:0] CORE_ID    = 32'h0,
  parameter logic        BYPASS_RST = 1'b1,
  parameter int unsigned SYNC_APPLY = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              frame_start,
  input  logic              lb_overflow,
  input  logic              lb_underflow,
  output logic              core_bypass,
  output logic [3:0]        core_mode
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CSR_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(CSR_STATUS);
  localparam logic [ADDR_W-1:0] A_FCNT   = ADDR_W'(CSR_FRAME_CNT);
  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(CSR_ID);

  localparam ctrl_t CTRL_RST = '{mode: 4'h0, bypass: BYPASS_RST};

  ctrl_t                 ctrl_reg;
  ctrl_t                 applied_reg;
  logic                  pending_reg;
  logic [NUM_STICKY-1:0] sticky_reg;
  logic [FCNT_W-1:0]     frame_cnt_reg;
  logic [31:0]           readdata_reg;
  logic                  rdvalid_reg;

  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_fcnt;
  ctrl_t                 ctrl_next;
  logic [NUM_STICKY-1:0] sticky_evt;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign wr_ctrl   = avs_write && (avs_address == A_CTRL);
  assign wr_status = avs_write && (avs_address == A_STATUS);
  assign wr_fcnt   = avs_write && (avs_address == A_FCNT);

  assign ctrl_next.mode   = avs_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign ctrl_next.bypass = avs_writedata[CTRL_BYPASS_BIT];

  assign sticky_evt   = {lb_underflow, lb_overflow};
  assign unused_wdata = ^{avs_writedata[31:8], avs_writedata[3]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctrl_reg <= CTRL_RST;
    end else if (wr_ctrl) begin
      ctrl_reg <= ctrl_next;
    end
  end

  generate
    if (SYNC_APPLY != 0) begin : g_sync_apply
      // frame_start applies the CTRL value held before this cycle's write;
      // a coincident write keeps pending set for the next frame.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          applied_reg <= CTRL_RST;
          pending_reg <= 1'b0;
        end else begin
          if (frame_start && pending_reg) begin
            applied_reg <= ctrl_reg;
          end
          if (wr_ctrl) begin
            pending_reg <= 1'b1;
          end else if (frame_start) begin
            pending_reg <= 1'b0;
          end
        end
      end
    end else begin : g_direct_apply
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          applied_reg <= CTRL_RST;
        end else if (wr_ctrl) begin
          applied_reg <= ctrl_next;
        end
      end
      assign pending_reg = 1'b0;
    end
  endgenerate

  // Sticky error flags: the event has priority over a coincident W1C.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STICKY; gi++) begin : g_sticky
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sticky_reg[gi] <= 1'b0;
        end else if (sticky_evt[gi]) begin
          sticky_reg[gi] <= 1'b1;
        end else if (wr_status && avs_writedata[STAT_OVF_BIT + gi]) begin
          sticky_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (sys_rst || wr_fcnt) begin
      frame_cnt_reg <= '0;
    end else if (frame_start) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (avs_address)
      A_CTRL: begin
        rd_mux[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_reg.mode;
        rd_mux[CTRL_BYPASS_BIT]             = ctrl_reg.bypass;
      end
      A_STATUS: begin
        rd_mux[STAT_BYPASS_BIT]  = applied_reg.bypass;
        rd_mux[STAT_OVF_BIT]     = sticky_reg[0];
        rd_mux[STAT_UNF_BIT]     = sticky_reg[1];
        rd_mux[STAT_PENDING_BIT] = pending_reg;
      end
      A_FCNT:  rd_mux[FCNT_W-1:0] = frame_cnt_reg;
      A_ID:    rd_mux = CORE_ID;
      default: rd_mux = 32'h0;
    endcase
  end

  // Read data is sampled from pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      readdata_reg <= 32'h0;
      rdvalid_reg  <= 1'b0;
    end else begin
      rdvalid_reg <= avs_read;
      if (avs_read) begin
        readdata_reg <= rd_mux;
      end
    end
  end

  assign avs_readdata      = readdata_reg;
  assign avs_readdatavalid = rdvalid_reg;
  assign core_bypass       = applied_reg.bypass;
  assign core_mode         = applied_reg.mode;

endmodule

// File: tb/tb_video_core_avs_csr.sv
// Directed self-checking bench for video_core_avs_csr (SYNC_APPLY=1, 3-bit address
// so that unmapped offsets can be exercised).
module tb_video_core_avs_csr;

  localparam int unsigned ADDR_W  = 3;
  localparam logic [31:0] CORE_ID = 32'hC0DE_0042;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = 32'h0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              frame_start = 1'b0;
  logic              lb_overflow = 1'b0;
  logic              lb_underflow = 1'b0;
  logic              core_bypass;
  logic [3:0]        core_mode;

  int n_cmp = 0;
  int n_bad = 0;

  video_core_avs_csr #(
    .ADDR_W    (ADDR_W),
    .CORE_ID   (CORE_ID),
    .BYPASS_RST(1'b1),
    .SYNC_APPLY(1)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .frame_start      (frame_start),
    .lb_overflow      (lb_overflow),
    .lb_underflow     (lb_underflow),
    .core_bypass      (core_bypass),
    .core_mode        (core_mode)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    chk({tag, ".valid"}, {31'b0, avs_readdatavalid}, 32'h1);
    chk(tag, avs_readdata, exp);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [ADDR_W-1:0] b2b_addr [5];
  logic [31:0]       b2b_exp  [5];

  initial begin
    // Reset, with a read issued in the final reset cycle.
    tick(); tick();
    avs_address = ADDR_W'(3);
    avs_read    = 1'b1;
    tick();
    sys_rst  = 1'b0;
    avs_read = 1'b0;
    chk("rst.bypass", {31'b0, core_bypass}, 32'h1);
    chk("rst.mode", {28'b0, core_mode}, 32'h0);
    chk("rst.rdvalid", {31'b0, avs_readdatavalid}, 32'h0);
    chk("rst.rdata", avs_readdata, 32'h0);
    tick();
    chk("rst.rdvalid2", {31'b0, avs_readdatavalid}, 32'h0);

    rd_chk("id", 3'd3, CORE_ID);
    tick();
    chk("rdata_hold", avs_readdata, CORE_ID);
    chk("rdvalid_low", {31'b0, avs_readdatavalid}, 32'h0);

    // Frame-synchronised CTRL apply.
    wr(3'd0, 32'h31);
    chk("sync.mode_held", {28'b0, core_mode}, 32'h0);
    chk("sync.byp_held", {31'b0, core_bypass}, 32'h1);
    rd_chk("sync.status_pend", 3'd1, 32'h9);
    rd_chk("sync.ctrl", 3'd0, 32'h31);
    pulse_frame();
    chk("sync.mode_applied", {28'b0, core_mode}, 32'h3);
    chk("sync.byp_applied", {31'b0, core_bypass}, 32'h1);
    rd_chk("sync.status_clr", 3'd1, 32'h1);

    // CTRL write coincident with frame_start: old value applied, new stays pending.
    wr(3'd0, 32'h50);
    frame_start = 1'b1;
    wr(3'd0, 32'h71);
    frame_start = 1'b0;
    chk("coin.mode_old", {28'b0, core_mode}, 32'h5);
    chk("coin.byp_old", {31'b0, core_bypass}, 32'h0);
    rd_chk("coin.status", 3'd1, 32'h8);
    pulse_frame();
    chk("coin.mode_new", {28'b0, core_mode}, 32'h7);
    chk("coin.byp_new", {31'b0, core_bypass}, 32'h1);
    rd_chk("coin.status2", 3'd1, 32'h1);

    // Sticky flags.
    lb_overflow = 1'b1; tick(); lb_overflow = 1'b0;
    rd_chk("ovf.set", 3'd1, 32'h3);
    lb_overflow = 1'b1;
    wr(3'd1, 32'h2);
    lb_overflow = 1'b0;
    rd_chk("ovf.set_wins", 3'd1, 32'h3);
    wr(3'd1, 32'h2);
    rd_chk("ovf.w1c", 3'd1, 32'h1);
    lb_underflow = 1'b1; tick(); lb_underflow = 1'b0;
    rd_chk("unf.set", 3'd1, 32'h5);
    wr(3'd1, 32'h2);
    rd_chk("unf.w1c_other", 3'd1, 32'h5);
    wr(3'd1, 32'h4);
    rd_chk("unf.w1c", 3'd1, 32'h1);

    // Writes to RO / unmapped offsets are ignored.
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    rd_chk("ro.id", 3'd3, CORE_ID);
    rd_chk("ro.ctrl", 3'd0, 32'h71);

    // Frame counter: 3 pulses so far, then clear, wrap, and clear-wins.
    rd_chk("fcnt.count", 3'd2, 32'h3);
    wr(3'd2, 32'h0);
    rd_chk("fcnt.clr", 3'd2, 32'h0);
    frame_start = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    frame_start = 1'b0;
    rd_chk("fcnt.ffff", 3'd2, 32'hFFFF);
    pulse_frame();
    pulse_frame();
    rd_chk("fcnt.wrap", 3'd2, 32'h1);
    frame_start = 1'b1;
    wr(3'd2, 32'h1234);
    frame_start = 1'b0;
    rd_chk("fcnt.clr_wins", 3'd2, 32'h0);

    // Back-to-back reads including an unmapped offset.
    b2b_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    b2b_exp  = '{32'h71, 32'h1, 32'h0, CORE_ID, 32'h0};
    for (int i = 0; i < 5; i++) begin
      avs_address = b2b_addr[i];
      avs_read    = 1'b1;
      tick();
      chk($sformatf("b2b[%0d].valid", i), {31'b0, avs_readdatavalid}, 32'h1);
      chk($sformatf("b2b[%0d].data", i), avs_readdata, b2b_exp[i]);
    end
    avs_read = 1'b0;
    tick();
    chk("b2b.valid_end", {31'b0, avs_readdatavalid}, 32'h0);

    // Read and write to CTRL in the same cycle returns the pre-write value.
    avs_address   = 3'd0;
    avs_writedata = 32'h20;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    tick();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    chk("rw.valid", {31'b0, avs_readdatavalid}, 32'h1);
    chk("rw.old", avs_readdata, 32'h71);
    rd_chk("rw.new", 3'd0, 32'h20);

    // Reset mid-operation returns everything to reset values.
    lb_overflow = 1'b1; tick(); lb_overflow = 1'b0;
    sys_rst  = 1'b1;
    avs_read = 1'b1;
    avs_address = 3'd3;
    tick();
    sys_rst  = 1'b0;
    avs_read = 1'b0;
    chk("rst2.rdvalid", {31'b0, avs_readdatavalid}, 32'h0);
    chk("rst2.mode", {28'b0, core_mode}, 32'h0);
    chk("rst2.bypass", {31'b0, core_bypass}, 32'h1);
    rd_chk("rst2.ctrl", 3'd0, 32'h1);
    rd_chk("rst2.status", 3'd1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
